sprite_anim_sched: RTL and testbench

- Sequences the sprite animation frame ROMs for up to NSPR characters (blue player, slime, ...).
- Replaces the free-running frame counter with per-sprite animation state machines.
- Frame indices advance only at vertical sync, so the pixel pipeline never changes ROM source mid-frame.
- Sits between game logic (mode requests) and the per-sprite ROM selection mux ahead of the VGA compositor.

---
 rtl/anim_pkg.sv | 86 ++++++++
 rtl/anim_channel.sv | 111 +++++++++++
 rtl/sprite_anim_sched.sv | 82 ++++++++
 tb/tb_sprite_anim_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/anim_pkg.sv
// Shared mode/state encodings and per-mode animation tables for sprite_anim_sched.
package anim_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'b00,
    MODE_RUN    = 2'b01,
    MODE_JUMP   = 2'b10,
    MODE_FREEZE = 2'b11
  } anim_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_JUMP,
    ST_JDONE,
    ST_FREEZE
  } chan_state_e;

  localparam int unsigned HOLD_W = 2;

  localparam int unsigned IDLE_BASE = 0;
  localparam int unsigned IDLE_LEN  = 4;
  localparam int unsigned IDLE_HOLD = 2;
  localparam bit          IDLE_ONESHOT = 1'b0;

  localparam int unsigned RUN_BASE = 4;
  localparam int unsigned RUN_LEN  = 8;
  localparam int unsigned RUN_HOLD = 1;
  localparam bit          RUN_ONESHOT = 1'b0;

  localparam int unsigned JUMP_BASE = 12;
  localparam int unsigned JUMP_LEN  = 4;
  localparam int unsigned JUMP_HOLD = 3;
  localparam bit          JUMP_ONESHOT = 1'b1;

  function automatic int unsigned mode_base(anim_mode_e m);
    case (m)
      MODE_IDLE: return IDLE_BASE;
      MODE_RUN:  return RUN_BASE;
      MODE_JUMP: return JUMP_BASE;
      default:   return 0;
    endcase
  endfunction

  function automatic int unsigned mode_len(anim_mode_e m);
    case (m)
      MODE_IDLE: return IDLE_LEN;
      MODE_RUN:  return RUN_LEN;
      MODE_JUMP: return JUMP_LEN;
      default:   return 1;
    endcase
  endfunction

  function automatic int unsigned mode_hold(anim_mode_e m);
    case (m)
      MODE_IDLE: return IDLE_HOLD;
      MODE_RUN:  return RUN_HOLD;
      MODE_JUMP: return JUMP_HOLD;
      default:   return 1;
    endcase
  endfunction

  function automatic bit mode_oneshot(anim_mode_e m);
    case (m)
      MODE_IDLE: return IDLE_ONESHOT;
      MODE_RUN:  return RUN_ONESHOT;
      MODE_JUMP: return JUMP_ONESHOT;
      default:   return 1'b0;
    endcase
  endfunction

  function automatic int unsigned last_frame(anim_mode_e m);
    return mode_base(m) + mode_len(m) - 1;
  endfunction

  // JDONE is still "JUMP" so a held JUMP request does not retrigger.
  function automatic anim_mode_e state_mode(chan_state_e s);
    case (s)
      ST_RUN:            return MODE_RUN;
      ST_JUMP, ST_JDONE: return MODE_JUMP;
      ST_FREEZE:         return MODE_FREEZE;
      default:           return MODE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/anim_channel.sv
// One sprite animation channel; all state changes happen on frame_tick_i.
// ANIM_PINGPONG_EN: IDLE bounces between its first and last frame instead of wrapping.
module anim_channel
  import anim_pkg::*;
#(
  parameter int unsigned FRAME_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               frame_tick_i,
  input  logic [1:0]         mode_req_i,
  output logic [FRAME_W-1:0] frame_idx_o,
  output logic               anim_done_o
);

  chan_state_e        state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               done_q, done_d;

  anim_mode_e         req_mode, cur_mode;
  logic [FRAME_W-1:0] base_f, last_f, step_f;
  logic [HOLD_W-1:0]  hold_last;

`ifdef ANIM_PINGPONG_EN
  logic dir_q, dir_d;
  logic dir_flip;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
`ifdef ANIM_PINGPONG_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
`ifdef ANIM_PINGPONG_EN
      dir_q   <= dir_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    hold_d    = hold_q;
    done_d    = 1'b0;
    req_mode  = anim_mode_e'(mode_req_i);
    cur_mode  = state_mode(state_q);
    base_f    = FRAME_W'(mode_base(cur_mode));
    last_f    = FRAME_W'(last_frame(cur_mode));
    hold_last = HOLD_W'(mode_hold(cur_mode) - 1);
    step_f    = (frame_q == last_f) ? base_f : frame_q + 1'b1;
`ifdef ANIM_PINGPONG_EN
    dir_d    = dir_q;
    dir_flip = 1'b0;
    if (state_q == ST_IDLE) begin
      dir_flip = dir_q ? (frame_q == base_f) : (frame_q == last_f);
      step_f   = (dir_q ^ dir_flip) ? frame_q - 1'b1 : frame_q + 1'b1;
    end
`endif

    if (frame_tick_i) begin
      if (req_mode != cur_mode) begin
        hold_d = '0;
        if (req_mode != MODE_FREEZE) frame_d = FRAME_W'(mode_base(req_mode));
`ifdef ANIM_PINGPONG_EN
        dir_d = 1'b0;
`endif
        unique case (req_mode)
          MODE_IDLE:   state_d = ST_IDLE;
          MODE_RUN:    state_d = ST_RUN;
          MODE_JUMP:   state_d = ST_JUMP;
          MODE_FREEZE: state_d = ST_FREEZE;
        endcase
      end else begin
        unique case (state_q)
          ST_IDLE, ST_RUN, ST_JUMP: begin
            if (hold_q < hold_last) begin
              hold_d = hold_q + 1'b1;
            end else begin
              hold_d  = '0;
              frame_d = step_f;
`ifdef ANIM_PINGPONG_EN
              dir_d   = dir_q ^ dir_flip;
`endif
              if (mode_oneshot(cur_mode) && (step_f == last_f)) begin
                state_d = ST_JDONE;
                done_d  = 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    frame_idx_o = frame_q;
    anim_done_o = done_q;
  end

endmodule

// File: rtl/sprite_anim_sched.sv
// Vsync-synchronised animation tick generator feeding NSPR sprite channels.
// Optional macro ANIM_PINGPONG_EN selects ping-pong IDLE playback in the channels.
module sprite_anim_sched
  import anim_pkg::*;
#(
  parameter int unsigned NSPR     = 2,
  parameter int unsigned FRAME_W  = 4,
  parameter int unsigned TICK_DIV = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vs,
  input  logic                    pause,
  input  logic [2*NSPR-1:0]       mode_req,
  output logic [FRAME_W*NSPR-1:0] frame_idx,
  output logic [NSPR-1:0]         anim_done,
  output logic                    frame_tick
);

  localparam int unsigned DIV_W = 4;

  if ((mode_base(MODE_IDLE) + mode_len(MODE_IDLE) > (1 << FRAME_W)) ||
      (mode_base(MODE_RUN)  + mode_len(MODE_RUN)  > (1 << FRAME_W)) ||
      (mode_base(MODE_JUMP) + mode_len(MODE_JUMP) > (1 << FRAME_W))) begin : g_bad_frame_w
    $error("sprite_anim_sched: mode frame range exceeds FRAME_W");
  end
  if ((TICK_DIV < 1) || (TICK_DIV > 15)) begin : g_bad_tick_div
    $error("sprite_anim_sched: TICK_DIV must be 1..15");
  end

  logic             vs_s1_q, vs_s2_q, vs_s3_q, vs_fall_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;

  // vs idles high, so the sync chain resets to 1 to avoid a false fall after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_s1_q   <= 1'b1;
      vs_s2_q   <= 1'b1;
      vs_s3_q   <= 1'b1;
      vs_fall_q <= 1'b0;
      div_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      vs_s1_q   <= vs;
      vs_s2_q   <= vs_s1_q;
      vs_s3_q   <= vs_s2_q;
      vs_fall_q <= vs_s3_q & ~vs_s2_q;
      div_q     <= div_d;
      tick_q    <= tick_d;
    end
  end

  always_comb begin
    div_d  = div_q;
    tick_d = 1'b0;
    if (vs_fall_q && !pause) begin
      if (div_q == DIV_W'(TICK_DIV - 1)) begin
        div_d  = '0;
        tick_d = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  assign frame_tick = tick_q;

  for (genvar i = 0; i < NSPR; i++) begin : g_chan
    anim_channel #(
      .FRAME_W(FRAME_W)
    ) u_chan (
      .clk_i       (clk),
      .rst_i       (rst),
      .frame_tick_i(tick_q),
      .mode_req_i  (mode_req[2*i +: 2]),
      .frame_idx_o (frame_idx[FRAME_W*i +: FRAME_W]),
      .anim_done_o (anim_done[i])
    );
  end

endmodule

// File: tb/tb_sprite_anim_sched.sv
// Scoreboard bench for sprite_anim_sched: stimulus predicts each tick, a monitor checks it.
module tb_sprite_anim_sched;

  localparam int NSPR     = 2;
  localparam int FRAME_W  = 4;
  localparam int TICK_DIV = 2;
  localparam int FW       = FRAME_W * NSPR;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            vs = 1'b1;
  logic            pause = 1'b0;
  logic [2*NSPR-1:0] mode_req = '0;
  logic [FW-1:0]   frame_idx;
  logic [NSPR-1:0] anim_done;
  logic            frame_tick;

  sprite_anim_sched #(
    .NSPR(NSPR),
    .FRAME_W(FRAME_W),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vs(vs),
    .pause(pause),
    .mode_req(mode_req),
    .frame_idx(frame_idx),
    .anim_done(anim_done),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              cyc;
    logic [FW-1:0]   frames;
    logic [NSPR-1:0] done;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // reference model: mode and ticks-since-entry per sprite
  int m_mode[NSPR];
  int m_age[NSPR];
  int m_frame[NSPR];
  int divcnt;

  function automatic void chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, expv, $time);
    end
  endfunction

  function automatic int idle_frame(int age);
`ifdef ANIM_PINGPONG_EN
    int p;
    p = (age / 2) % 6;
    return (p < 4) ? p : 6 - p;
`else
    return (age / 2) % 4;
`endif
  endfunction

  function automatic void model_reset();
    divcnt = 0;
    for (int s = 0; s < NSPR; s++) begin
      m_mode[s]  = 0;
      m_age[s]   = 0;
      m_frame[s] = 0;
    end
  endfunction

  task automatic model_fall(input int c0);
    exp_t e;
    if (pause) return;
    divcnt++;
    if (divcnt < TICK_DIV) return;
    divcnt   = 0;
    e.cyc    = c0 + 4;
    e.frames = '0;
    e.done   = '0;
    for (int s = 0; s < NSPR; s++) begin
      int req;
      req = int'(mode_req[2*s +: 2]);
      if (req != m_mode[s]) begin
        m_mode[s] = req;
        m_age[s]  = 0;
      end else begin
        m_age[s]++;
      end
      case (m_mode[s])
        0: m_frame[s] = idle_frame(m_age[s]);
        1: m_frame[s] = 4 + (m_age[s] % 8);
        2: begin
          m_frame[s] = 12 + ((m_age[s] / 3 > 3) ? 3 : m_age[s] / 3);
          e.done[s]  = (m_age[s] == 9);
        end
        default: ;
      endcase
      e.frames[FRAME_W*s +: FRAME_W] = FRAME_W'(m_frame[s]);
    end
    exp_q.push_back(e);
  endtask

  task automatic vsync_period(input int lo, input int hi);
    int c0;
    @(negedge clk);
    vs = 1'b0;
    c0 = cyc;
    model_fall(c0);
    repeat (lo) @(negedge clk);
    vs = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  task automatic vsp(input int n);
    for (int i = 0; i < n; i++) vsync_period(3, 9);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_frame_idx", int'(frame_idx), 0);
    chk("rst_anim_done", int'(anim_done), 0);
    chk("rst_frame_tick", int'(frame_tick), 0);
    model_reset();
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    logic pend;
    logic [FW-1:0] prev_f;
    pend   = 1'b0;
    prev_f = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend   = 1'b0;
        prev_f = frame_idx;
      end else begin
        if (pend) begin
          chk("tick_frame_idx", int'(frame_idx), int'(e.frames));
          chk("tick_anim_done", int'(anim_done), int'(e.done));
          pend = 1'b0;
        end else begin
          chk("stable_frame_idx", int'(frame_idx), int'(prev_f));
          chk("idle_anim_done", int'(anim_done), 0);
        end
        if (frame_tick) begin
          chk("tick_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("tick_cycle", cyc, e.cyc);
            pend = 1'b1;
          end
        end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
          chk("tick_missing", int'(frame_tick), 1);
          void'(exp_q.pop_front());
        end
        prev_f = frame_idx;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int guard;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();
    repeat (4) @(negedge clk);

    // all sprites idle
    vsp(20);
    // sprite0 run, sprite1 idle
    mode_req = 4'b0001;
    vsp(22);
    // sprite0 one-shot jump, then long hold at last frame
    mode_req = 4'b0010;
    vsp(64);
    // run to frame 6, then pause across 10 vsyncs with divider mid-count
    mode_req = 4'b0001;
    vsp(6);
    vsp(1);
    pause = 1'b1;
    vsp(10);
    pause = 1'b0;
    vsp(6);
    // reset in the middle of a jump
    mode_req = 4'b0010;
    guard = 0;
    while (!(m_mode[0] == 2 && m_frame[0] == 13) && guard < 40) begin
      vsp(1);
      guard++;
    end
    chk("jump_reached_13", m_frame[0], 13);
    do_reset();
    repeat (2) @(negedge clk);
    vsp(6);
    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) mode_req = 4'($urandom_range(0, 15));
      pause = ($urandom_range(0, 7) == 0);
      vsync_period($urandom_range(2, 5), $urandom_range(7, 12));
    end
    pause = 1'b0;
    repeat (10) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
